// File: rtl/fifo_pkg.sv
// Shared definitions for the async-FIFO read/write handlers and arbiters.
//   - arb_state_e : arbiter FSM state encoding (IDLE, BURST)
//   - ch_width()  : channel-index width for a given channel count
//   - DEF_DATA_WIDTH / DEF_ADDRSIZE : default FIFO word width and address size
package fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDRSIZE   = 4;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority selector.
// Scans req starting at last+1 and wrapping modulo NUM_CH; the channel named
// by last is considered last of all.
//   req   [NUM_CH] : request vector (1 = wants service)
//   last  [CH_W]   : most recently served channel
//   found          : at least one request present
//   idx   [CH_W]   : winning channel (0 when found = 0)
module rr_pick
  import fifo_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last,
  output logic              found,
  output logic [CH_W-1:0]   idx
);

  logic [CH_W-1:0] cand;

  // Walk from the farthest candidate (last itself) to the nearest (last+1);
  // the final hit written is therefore the nearest one in round-robin order.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = CH_W'((int'(last) + i) % NUM_CH);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Read-side scheduler sharing one consumer between NUM_CH FIFO read ports.
// Grants one channel at a time (round-robin) for up to MAX_BURST pops, then
// re-arbitrates. Each pop captures that channel's combinational read data into
// a one-entry output register.
//   rd_clk, rd_rst : read-domain clock, async active-low reset
//   ch_empty       : per-channel registered empty flag (1 = empty)
//   ch_rd_data     : per-channel read data, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   ch_rd_en       : per-channel pop strobe (at most one bit set)
//   out_valid/out_ready/out_data/out_ch : output word, its source channel, handshake
//   busy           : FSM is in BURST (doubles as the observable state bit)
//
// Output handshake: a word transfers on a rising edge where out_valid and
// out_ready are both high. out_valid, out_data and out_ch stay constant while
// out_valid && !out_ready. A new word may be loaded in the same cycle the
// current one transfers, giving one word per cycle back-to-back.
module fifo_rd_arbiter
  import fifo_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int MAX_BURST  = 4,
  localparam int CH_W       = ch_width(NUM_CH)
) (
  input  logic                         rd_clk,
  input  logic                         rd_rst,
  input  logic [NUM_CH-1:0]            ch_empty,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_rd_data,
  output logic [NUM_CH-1:0]            ch_rd_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]              out_ch,
  output logic                         busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_e            state_q, state_d;
  logic [CH_W-1:0]       grant_q, grant_d;
  logic [CH_W-1:0]       last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]       out_ch_q, out_ch_d;

  logic [DATA_WIDTH-1:0] ch_word [NUM_CH];
  logic [NUM_CH-1:0]     req;
  logic                  pick_found;
  logic [CH_W-1:0]       pick_idx;
  logic                  space;
  logic                  sel_empty;
  logic                  pop;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ch_word[k] = ch_rd_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign req = ~ch_empty;

  rr_pick #(
    .NUM_CH (NUM_CH)
  ) u_rr_pick (
    .req   (req),
    .last  (last_grant_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Popping is driven only by the registered empty flag of the granted
  // channel; no lookahead on the handler's pointers.
  assign space     = !out_valid_q || out_ready;
  assign sel_empty = ch_empty[grant_q];
  assign pop       = (state_q == BURST) && !sel_empty && space;
  assign ch_rd_en  = pop ? (NUM_CH'(1) << grant_q) : '0;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;

    if (pop) begin
      out_data_d  = ch_word[grant_q];
      out_ch_d    = grant_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = BURST;
        end
      end
      BURST: begin
        if (pop) begin
          // The count stops at MAX_BURST-1; the last pop of a burst clears it.
          if (burst_cnt_q == CNT_LAST) begin
            burst_cnt_d  = '0;
            last_grant_d = grant_q;
            state_d      = IDLE;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end else if (sel_empty) begin
          // Channel drained before the burst limit.
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
        // Otherwise stalled on a full output register: hold everything.
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      burst_cnt_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign busy      = (state_q == BURST);

  a_rd_en_onehot0 : assert property (@(posedge rd_clk) disable iff (!rd_rst)
    $onehot0(ch_rd_en));

  a_rd_en_not_empty : assert property (@(posedge rd_clk) disable iff (!rd_rst)
    (ch_rd_en & ch_empty) == '0);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
module tb_fifo_rd_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 8;

  // ---------------- clock / reset ----------------
  logic           rd_clk = 1'b0;
  logic           rd_rst = 1'b0;
  logic [NCH-1:0] ch_empty = '1;
  logic [NCH*DW-1:0] ch_rd_data = '0;
  logic [NCH-1:0] ch_rd_en;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [DW-1:0]  out_data;
  logic [1:0]     out_ch;
  logic           busy;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_arbiter #(
    .NUM_CH     (NCH),
    .DATA_WIDTH (DW),
    .MAX_BURST  (4)
  ) dut (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .ch_empty   (ch_empty),
    .ch_rd_data (ch_rd_data),
    .ch_rd_en   (ch_rd_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .busy       (busy)
  );

  // ---------------- checker ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- FIFO read-handler model ----------------
  logic [DW-1:0] mem  [NCH][16];
  logic [3:0]    head [NCH] = '{default: '0};
  logic [3:0]    tail [NCH] = '{default: '0};
  logic [NCH-1:0] pop_en;
  logic           acc_q;
  logic [9:0]     acc_word;
  logic [9:0]     exp_q[$];

  // Pops and transfers as seen by the edge that performs them.
  always @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      pop_en   <= '0;
      acc_q    <= 1'b0;
      acc_word <= '0;
    end else begin
      pop_en   <= ch_rd_en;
      acc_q    <= out_valid && out_ready;
      acc_word <= {out_ch, out_data};
    end
  end

  // Handler: advance read pointer, then present registered empty + data.
  // Scoreboard: every transferred word must match the head of exp_q.
  always @(posedge rd_clk) begin
    #2;
    for (int k = 0; k < NCH; k++) begin
      if (pop_en[k]) head[k] = head[k] + 4'd1;
    end
    if (acc_q) begin
      if (exp_q.size() == 0) check_eq("spurious_word", exp_q.size(), 1);
      else check_eq("out_word", acc_word, exp_q.pop_front());
    end
    for (int k = 0; k < NCH; k++) begin
      ch_empty[k] = (head[k] == tail[k]);
      ch_rd_data[k*DW +: DW] = mem[k][head[k]];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic neg();
    @(negedge rd_clk);
  endtask

  task automatic load(input int ch, input logic [DW-1:0] w);
    mem[ch][tail[ch]] = w;
    tail[ch] = tail[ch] + 4'd1;
  endtask

  task automatic expect_word(input logic [1:0] ch, input logic [DW-1:0] w);
    exp_q.push_back({ch, w});
  endtask

  // Expected {busy, ch_rd_en} per negedge after the load negedge.
  logic [4:0] t2 [6]  = '{5'h00, 5'h14, 5'h14, 5'h14, 5'h10, 5'h00};
  logic [4:0] t3 [19] = '{5'h00, 5'h11, 5'h11, 5'h11, 5'h11, 5'h00,
                          5'h12, 5'h12, 5'h12, 5'h12, 5'h00,
                          5'h11, 5'h11, 5'h10, 5'h00,
                          5'h12, 5'h12, 5'h10, 5'h00};
  logic [4:0] t5 [7]  = '{5'h00, 5'h11, 5'h10, 5'h00, 5'h18, 5'h10, 5'h00};
  logic [4:0] t6 [7]  = '{5'h11, 5'h10, 5'h00, 5'h12, 5'h12, 5'h10, 5'h00};

  // ---------------- stimulus ----------------
  initial begin
    // Reset values
    neg();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_ch", out_ch, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rd_en", ch_rd_en, 0);
    neg();
    rd_rst = 1'b1;

    // All channels empty: nothing happens
    for (int i = 0; i < 20; i++) begin
      neg();
      check_eq($sformatf("idle_cyc%0d", i), {busy, ch_rd_en, out_valid}, 0);
    end

    // Ch2 with A,B,C (last_grant = 3)
    load(2, 8'hA1); load(2, 8'hB2); load(2, 8'hC3);
    expect_word(2, 8'hA1); expect_word(2, 8'hB2); expect_word(2, 8'hC3);
    for (int i = 0; i < 6; i++) begin
      neg();
      check_eq($sformatf("t2_cyc%0d", i), {busy, ch_rd_en}, t2[i]);
      if (i == 2) begin
        check_eq("t2_first_data", out_data, 8'hA1);
        check_eq("t2_first_ch", out_ch, 2);
      end
    end
    check_eq("t2_valid_end", out_valid, 0);

    // Ch0 and ch1 with 6 words each, bursts of 4 then 2 (last_grant = 2)
    for (int i = 0; i < 6; i++) begin
      load(0, 8'h10 + 8'(i));
      load(1, 8'h20 + 8'(i));
    end
    for (int i = 0; i < 4; i++) expect_word(0, 8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) expect_word(1, 8'h20 + 8'(i));
    for (int i = 4; i < 6; i++) expect_word(0, 8'h10 + 8'(i));
    for (int i = 4; i < 6; i++) expect_word(1, 8'h20 + 8'(i));
    for (int i = 0; i < 19; i++) begin
      neg();
      check_eq($sformatf("t3_cyc%0d", i), {busy, ch_rd_en}, t3[i]);
    end

    // Ch3 burst with out_ready 1,0,0,1 (last_grant = 1)
    for (int i = 0; i < 4; i++) begin
      load(3, 8'hD0 + 8'(i));
      expect_word(3, 8'hD0 + 8'(i));
    end
    neg(); check_eq("t4_n1", {busy, ch_rd_en}, 5'h00);
    neg(); check_eq("t4_n2", {busy, ch_rd_en}, 5'h18);
    neg(); out_ready = 1'b0; #1;
    check_eq("t4_stall1", {busy, ch_rd_en}, 5'h10);
    check_eq("t4_stall1_data", out_data, 8'hD0);
    check_eq("t4_stall1_valid", out_valid, 1);
    neg();
    check_eq("t4_stall2", {busy, ch_rd_en}, 5'h10);
    check_eq("t4_stall2_data", out_data, 8'hD0);
    neg(); out_ready = 1'b1; #1;
    check_eq("t4_resume", {busy, ch_rd_en}, 5'h18);
    check_eq("t4_resume_data", out_data, 8'hD0);
    neg(); check_eq("t4_n6", {busy, ch_rd_en}, 5'h18);
    check_eq("t4_n6_data", out_data, 8'hD1);
    neg(); check_eq("t4_n7", {busy, ch_rd_en}, 5'h18);
    neg(); check_eq("t4_n8", {busy, ch_rd_en}, 5'h00);
    check_eq("t4_n8_data", out_data, 8'hD3);

    // Wrap-around: last_grant = 3, ch0 and ch3 ready -> ch0 first
    load(0, 8'h5A); load(3, 8'h5B);
    expect_word(0, 8'h5A); expect_word(3, 8'h5B);
    for (int i = 0; i < 7; i++) begin
      neg();
      check_eq($sformatf("t5_cyc%0d", i), {busy, ch_rd_en}, t5[i]);
      if (i == 2) check_eq("t5_wrap_ch", out_ch, 0);
    end

    // Reset mid-burst on ch1 after 2 pops (last_grant = 3)
    for (int i = 0; i < 4; i++) load(1, 8'hE0 + 8'(i));
    expect_word(1, 8'hE0);
    neg(); check_eq("t6_n1", {busy, ch_rd_en}, 5'h00);
    neg(); check_eq("t6_n2", {busy, ch_rd_en}, 5'h12);
    neg(); check_eq("t6_n3", {busy, ch_rd_en}, 5'h12);
    neg(); check_eq("t6_n4", {busy, ch_rd_en}, 5'h12);
    rd_rst = 1'b0; #1;
    check_eq("t6_rst_async", {busy, ch_rd_en, out_valid}, 0);
    check_eq("t6_rst_data", out_data, 0);
    check_eq("t6_rst_exp_empty", exp_q.size(), 0);
    exp_q.delete();
    load(0, 8'hF0);
    expect_word(0, 8'hF0); expect_word(1, 8'hE2); expect_word(1, 8'hE3);
    neg(); check_eq("t6_in_rst", {busy, out_valid}, 0);
    neg(); rd_rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      neg();
      check_eq($sformatf("t6_cyc%0d", i), {busy, ch_rd_en}, t6[i]);
      if (i == 1) check_eq("t6_scan_from0_ch", out_ch, 0);
    end

    neg(); neg(); neg();
    check_eq("drain_exp_q", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
